// File: rtl/pd1_mem_stream_master.sv
// Stream <-> Avalon-MM word mover: writes a stream into memory or reads memory out to a stream.
// Define PD1_MEM_STREAM_MASTER_READBACK_EN to build the READ path (output FIFO, m_* stream).
module pd1_mem_stream_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_read,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [ADDR_W:0]     cmd_len,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    output logic                s_ready,
    output logic                m_valid,
    output logic [DATA_W-1:0]   m_data,
    input  logic                m_ready,
    output logic [ADDR_W-1:0]   av_address,
    output logic                av_chipselect,
    output logic                av_write,
    output logic                av_clken,
    output logic [DATA_W-1:0]   av_writedata,
    output logic [DATA_W/8-1:0] av_byteenable,
    input  logic [DATA_W-1:0]   av_readdata,
    output logic                busy,
    output logic                done
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     remaining;
    logic                accept;
    logic                wr_xfer;
    logic                rd_issue;
    logic                pop;

    assign accept  = cmd_valid && cmd_ready;
    assign wr_xfer = (state == WRITE) && s_valid;

    assign cmd_ready     = (state == IDLE) && !reset;
    assign s_ready       = (state == WRITE);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign av_clken      = !reset;
    assign av_byteenable = {BE_W{!reset}};
    assign av_address    = addr;
    assign av_write      = wr_xfer;
    assign av_chipselect = wr_xfer || rd_issue;
    assign av_writedata  = (state == WRITE) ? s_data : '0;

`ifdef PD1_MEM_STREAM_MASTER_READBACK_EN
    logic [ADDR_W:0]   issue_left;
    logic              rd_pend;
    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [DATA_W-1:0] fifo_mem [2];
    logic [2:0]        occ_next;

    assign m_valid = (count != 2'd0);
    assign m_data  = fifo_mem[rd_ptr];
    assign pop     = m_valid && m_ready;

    // Occupancy after this cycle's pop; issuing keeps in-flight + buffered at most 2.
    assign occ_next = {2'b0, rd_pend} + {1'b0, count} - {2'b0, pop};
    assign rd_issue = (state == READ) && (issue_left != '0) && (occ_next < 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_left  <= '0;
            rd_pend     <= 1'b0;
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            rd_pend <= rd_issue;
            if (accept)
                issue_left <= cmd_len;
            else if (rd_issue)
                issue_left <= issue_left - 1'b1;
            if (rd_pend) begin
                fifo_mem[wr_ptr] <= av_readdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, rd_pend} - {1'b0, pop};
        end
    end
`else
    logic unused_inputs;

    assign m_valid       = 1'b0;
    assign m_data        = '0;
    assign pop           = 1'b0;
    assign rd_issue      = 1'b0;
    assign unused_inputs = ^{av_readdata, m_ready};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr      <= cmd_addr;
                        remaining <= cmd_len;
                        if (cmd_len == '0)
                            state <= DONE;
`ifdef PD1_MEM_STREAM_MASTER_READBACK_EN
                        else if (cmd_read)
                            state <= READ;
`else
                        else if (cmd_read)
                            state <= DONE;
`endif
                        else
                            state <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_xfer) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == (ADDR_W+1)'(1))
                            state <= DONE;
                    end
                end
                READ: begin
                    // Address tracks issued reads; completion tracks words delivered on m.
                    if (rd_issue)
                        addr <= addr + 1'b1;
                    if (pop) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == (ADDR_W+1)'(1))
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pd1_mem_stream_master.md
PD1_MEM_STREAM_MASTER -- requirements
Module: pd1_mem_stream_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the target memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when both valid and ready are high.
REQ-007 SHALL have port cmd_read  input  1  0 = write (stream to memory), 1 = read (memory to stream).
REQ-008 SHALL have port cmd_addr  input  ADDR_W  start word address.
REQ-009 SHALL have port cmd_len  input  ADDR_W+1  word count, 0..2^ADDR_W.
REQ-010 SHALL have port s_valid / s_data / s_ready  input 1 / input DATA_W / output 1  write-data stream.
REQ-011 SHALL have port m_valid / m_data / m_ready  output 1 / output DATA_W / input 1  read-data stream.
REQ-012 SHALL have port av_address  output  ADDR_W  Avalon-MM word address.
REQ-013 SHALL have ports av_chipselect, av_write, av_clken  output  1 each  Avalon-MM controls.
REQ-014 SHALL have ports av_writedata  output  DATA_W; av_byteenable  output  DATA_W/8; av_readdata  input  DATA_W.
REQ-015 SHALL have ports busy  output  1  (high outside IDLE) and done  output  1  (one-cycle completion pulse).

Function
REQ-016 SHALL implement states IDLE, WRITE, READ, DONE; cmd_ready high only in IDLE.
REQ-017 On command accept, SHALL latch addr/len/read; len 0 -> DONE directly; else WRITE or READ.
REQ-018 In WRITE: s_ready = 1; each s_valid&s_ready cycle drives av_chipselect=1, av_write=1, av_writedata=s_data, av_address=current address, same cycle.
REQ-019 av_byteenable SHALL be all ones; av_clken SHALL be constant 1 outside reset.
REQ-020 Address SHALL increment by 1 per transfer and wrap modulo 2^ADDR_W (1023 -> 0 at default).
REQ-021 Memory read latency is fixed at 1 cycle: av_readdata is valid the cycle after chipselect with write=0.
REQ-022 In READ: SHALL issue a read (chipselect=1, write=0) only when outstanding reads plus buffered words < 2; 2-entry output FIFO captures av_readdata.
REQ-023 m_valid SHALL be high whenever the output FIFO is non-empty; data in address order; m_ready low SHALL never lose data.
REQ-024 Sustained throughput SHALL be 1 word/cycle in both modes with s_valid / m_ready held high.
REQ-025 WRITE -> DONE after the len-th transfer; READ -> DONE after the len-th word leaves on m; DONE -> IDLE next cycle with done=1 for that one cycle.
REQ-026 av_chipselect and av_write SHALL be 0 in IDLE and DONE; no access beyond len words.

Reset
REQ-027 Reset asserted at any time, including mid-command, SHALL force IDLE asynchronously; output FIFO emptied; in-flight read discarded.
REQ-028 Reset values: cmd_ready=0 while reset high then 1; s_ready=0, m_valid=0, m_data=0, av_*=0 (av_clken 0), busy=0, done=0.

Configuration
REQ-029 Macro PD1_MEM_STREAM_MASTER_READBACK_EN SHALL compile in READ state, output FIFO, m_* drive.
REQ-030 Without it: m_valid tied 0, m_data tied 0, av_readdata ignored; cmd_read=1 commands accepted and go straight to DONE (done pulse, no memory access).

Verification
REQ-031 Write cmd addr=0x010 len=4, s_data 0xA0..0xA3 back-to-back -> av_write on 4 consecutive cycles, addr 0x010..0x013, done 1 cycle after last.
REQ-032 Read cmd addr=0x3FE len=4 with memory model (1-cycle latency) -> av_address 0x3FE,0x3FF,0x000,0x001; m_data in same order.
REQ-033 Read len=8, m_ready toggled 1/0 every cycle -> no word lost/duplicated, never >2 reads outstanding+buffered.
REQ-034 Write len=0 -> no av access, done pulse 1 cycle after accept; cmd_ready back high next cycle.
REQ-035 Reset asserted mid-write after 2 of 6 words -> immediate IDLE, all av_* 0; new command afterwards completes normally.
REQ-036 Build without macro, read cmd len=5 -> zero av_chipselect cycles, m_valid stays 0, done pulse.
